// File: rtl/demux_scheduler_if.sv
// Bundle of producer-side and consumer-side signals for the demux scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface demux_scheduler_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_dest;
  logic        mode;
  logic [15:0] chan_en;
  logic [15:0] out_valid;
  logic [15:0] out_data;
  logic [15:0] out_ready;
  logic        drop;
  logic        busy;
  logic [7:0]  xfer_count;

  modport slave (
    input  in_valid, in_data, in_dest, mode, chan_en, out_ready,
    output in_ready, out_valid, out_data, drop, busy, xfer_count
  );

  modport master (
    output in_valid, in_data, in_dest, mode, chan_en, out_ready,
    input  in_ready, out_valid, out_data, drop, busy, xfer_count
  );
endinterface

// File: rtl/demux_scheduler.sv
// Single-word demultiplexer: captures one word and offers it to one of 16
// channels, selected by address or by a round-robin search over enabled channels.
module demux_scheduler (
  input  logic               clk,
  input  logic               rst,
  demux_scheduler_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  dest_q;
  logic [3:0]  rr_ptr;
  logic [15:0] data_q;
  logic        drop_q;
  logic [7:0]  count_q;

  logic [3:0]  cand;
  logic [3:0]  rr_dest;
  logic        rr_found;
  logic [3:0]  sel_dest;
  logic        sel_ok;
  logic        accept;
  logic        complete;
  logic [15:0] valid_vec;

  // Search upward from the slot after rr_ptr; rr_ptr itself is the last candidate.
  always_comb begin
    rr_found = 1'b0;
    rr_dest  = rr_ptr;
    cand     = rr_ptr;
    for (int i = 1; i <= 16; i++) begin
      cand = rr_ptr + 4'(i);
      if (!rr_found && bus.chan_en[cand]) begin
        rr_found = 1'b1;
        rr_dest  = cand;
      end
    end
  end

  always_comb begin
    sel_dest = bus.mode ? rr_dest : bus.in_dest;
    sel_ok   = bus.mode ? rr_found : bus.chan_en[bus.in_dest];
    accept   = (state == IDLE) && bus.in_valid;
    complete = (state == SEND) && bus.out_ready[dest_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && sel_ok) state_next = SEND;
      SEND:    if (complete)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Destination is frozen at acceptance so later mode/enable changes cannot redirect it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 16'h0000;
      dest_q  <= 4'h0;
      drop_q  <= 1'b0;
      count_q <= 8'h00;
      rr_ptr  <= 4'hF;
    end else begin
      drop_q <= 1'b0;
      if (accept) begin
        data_q <= bus.in_data;
        if (sel_ok) begin
          dest_q <= sel_dest;
        end else begin
          drop_q <= 1'b1;
        end
      end
      if (complete) begin
        rr_ptr  <= dest_q;
        count_q <= count_q + 8'd1;
      end
    end
  end

  always_comb begin
    valid_vec = 16'h0000;
    if (state == SEND) valid_vec[dest_q] = 1'b1;
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.busy       = (state == SEND);
  assign bus.out_valid  = valid_vec;
  assign bus.out_data   = data_q;
  assign bus.drop       = drop_q;
  assign bus.xfer_count = count_q;

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler; inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_demux_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  demux_scheduler_if bus ();

  demux_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic [3:0] dest,
                               input logic md, input logic [15:0] en, input logic [15:0] rdy);
    bus.in_valid  = valid;
    bus.in_data   = data;
    bus.in_dest   = dest;
    bus.mode      = md;
    bus.chan_en   = en;
    bus.out_ready = rdy;
  endtask

  task automatic checkIdle(input string tag, input logic [7:0] count);
    checkOutput({tag, "_in_ready"}, 16'(bus.in_ready), 16'h0001);
    checkOutput({tag, "_busy"}, 16'(bus.busy), 16'h0000);
    checkOutput({tag, "_out_valid"}, bus.out_valid, 16'h0000);
    checkOutput({tag, "_count"}, 16'(bus.xfer_count), 16'(count));
  endtask

  logic [15:0] rr_expect [5];

  initial begin
    checks = 0;
    errors = 0;
    rr_expect[0] = 16'h0001;
    rr_expect[1] = 16'h0010;
    rr_expect[2] = 16'h8000;
    rr_expect[3] = 16'h0001;
    rr_expect[4] = 16'h0010;

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 16'h0000, 16'h0000);
    step();
    step();
    rst = 1'b0;
    checkIdle("reset", 8'h00);
    checkOutput("reset_out_data", bus.out_data, 16'h0000);
    checkOutput("reset_drop", 16'(bus.drop), 16'h0000);

    // Addressed sweep over every channel
    for (int d = 0; d < 16; d++) begin
      applyStimulus(1'b1, 16'hFFFF, 4'(d), 1'b0, 16'hFFFF, 16'hFFFF);
      step();
      bus.in_valid = 1'b0;
      checkOutput("sweep_out_valid", bus.out_valid, 16'h0001 << d);
      checkOutput("sweep_out_data", bus.out_data, 16'hFFFF);
      checkOutput("sweep_in_ready", 16'(bus.in_ready), 16'h0000);
      step();
      checkOutput("sweep_done_out_valid", bus.out_valid, 16'h0000);
    end
    checkIdle("sweep_end", 8'd16);

    // Backpressure on channel 5; other ready bits and late mode/enable changes are ignored
    applyStimulus(1'b1, 16'h1234, 4'd5, 1'b0, 16'hFFFF, 16'hFFDF);
    step();
    bus.in_valid = 1'b0;
    bus.mode     = 1'b1;
    bus.chan_en  = 16'h0000;
    for (int c = 0; c < 4; c++) begin
      checkOutput("bp_out_valid", bus.out_valid, 16'h0020);
      checkOutput("bp_out_data", bus.out_data, 16'h1234);
      checkOutput("bp_in_ready", 16'(bus.in_ready), 16'h0000);
      step();
    end
    bus.out_ready = 16'hFFFF;
    checkOutput("bp_last_out_valid", bus.out_valid, 16'h0020);
    step();
    checkIdle("bp_end", 8'd17);
    checkOutput("bp_hold_data", bus.out_data, 16'h1234);

    // Reset while offering to channel 8; rst overrides in_valid and out_ready
    applyStimulus(1'b1, 16'hABCD, 4'd8, 1'b0, 16'hFFFF, 16'h0000);
    step();
    bus.in_valid = 1'b0;
    checkOutput("rst_send_out_valid", bus.out_valid, 16'h0100);
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 16'hFFFF;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    checkIdle("rst_mid", 8'h00);
    checkOutput("rst_mid_out_data", bus.out_data, 16'h0000);
    checkOutput("rst_mid_drop", 16'(bus.drop), 16'h0000);

    // Round-robin with skip and wrap over channels 0, 4, 15
    for (int w = 0; w < 5; w++) begin
      applyStimulus(1'b1, 16'(16'h0A00 + w), 4'd9, 1'b1, 16'h8011, 16'hFFFF);
      step();
      bus.in_valid = 1'b0;
      checkOutput("rr_grant", bus.out_valid, rr_expect[w]);
      checkOutput("rr_data", bus.out_data, 16'(16'h0A00 + w));
      step();
    end
    checkIdle("rr_end", 8'd5);

    // Drop: addressed to a disabled channel
    applyStimulus(1'b1, 16'h5555, 4'd0, 1'b0, 16'hFFFE, 16'hFFFF);
    step();
    bus.in_valid = 1'b0;
    checkOutput("drop_addr_pulse", 16'(bus.drop), 16'h0001);
    checkIdle("drop_addr", 8'd5);
    step();
    checkOutput("drop_addr_clear", 16'(bus.drop), 16'h0000);

    // Drop: round-robin with nothing enabled
    applyStimulus(1'b1, 16'h6666, 4'd3, 1'b1, 16'h0000, 16'hFFFF);
    step();
    bus.in_valid = 1'b0;
    checkOutput("drop_rr_pulse", 16'(bus.drop), 16'h0001);
    checkIdle("drop_rr", 8'd5);
    step();
    checkOutput("drop_rr_clear", 16'(bus.drop), 16'h0000);

    // Drops must not have moved the pointer: last grant was 4, so next is 15
    applyStimulus(1'b1, 16'h7777, 4'd0, 1'b1, 16'h8011, 16'hFFFF);
    step();
    bus.in_valid = 1'b0;
    checkOutput("rr_after_drop", bus.out_valid, 16'h8000);
    step();
    checkIdle("rr_after_drop_end", 8'd6);

    // Counter wrap after 256 transfers from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(1'b1, 16'h0F0F, 4'd3, 1'b0, 16'hFFFF, 16'hFFFF);
    for (int t = 1; t <= 256; t++) begin
      step();
      step();
      if (t == 255) checkOutput("wrap_255", 16'(bus.xfer_count), 16'h00FF);
    end
    bus.in_valid = 1'b0;
    checkOutput("wrap_0", 16'(bus.xfer_count), 16'h0000);
    checkOutput("wrap_in_ready", 16'(bus.in_ready), 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_scheduler.md
DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 Parameters: none; data width fixed at 16 bits, channel count fixed at 16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  producer offers a word.
REQ-005 in_ready  output  1  scheduler can accept a word this cycle.
REQ-006 in_data  input  16  word to dispatch.
REQ-007 in_dest  input  4  destination channel (addressed mode only).
REQ-008 mode  input  1  0 = addressed, 1 = round-robin.
REQ-009 chan_en  input  16  per-channel enable mask.
REQ-010 out_valid  output  16  one-hot; bit k = word offered to channel k.
REQ-011 out_data  output  16  held word, shared by all channels.
REQ-012 out_ready  input  16  per-channel consumer ready.
REQ-013 drop  output  1  one-cycle pulse: accepted word discarded.
REQ-014 busy  output  1  high while in SEND.
REQ-015 xfer_count  output  8  completed transfers, modulo 256.

Function
REQ-016 FSM has two states, IDLE and SEND; in_ready = 1 only in IDLE; busy = 1 only in SEND.
REQ-017 IDLE, in_valid = 1: in_data captured into holding register, mode and chan_en sampled that same cycle.
REQ-018 Destination: addressed mode uses in_dest; round-robin mode uses the first enabled channel strictly after rr_ptr, searching upward with wrap 15 -> 0, rr_ptr itself being last candidate.
REQ-019 Destination disabled (addressed) or chan_en = 0 (round-robin): word discarded, drop = 1 on the next cycle, FSM stays IDLE, rr_ptr and xfer_count unchanged.
REQ-020 Otherwise FSM enters SEND next edge; out_valid[dest] = 1 starting the cycle after acceptance (latency 1), all other out_valid bits 0.
REQ-021 SEND: out_valid and out_data held stable until out_ready[dest] = 1; out_ready bits of other channels ignored.
REQ-022 Transfer completes on the edge where out_valid[dest] and out_ready[dest] are both 1: FSM -> IDLE, rr_ptr <= dest, xfer_count increments by 1 (255 wraps to 0).
REQ-023 Back-to-back throughput: one word per two cycles minimum; no new word accepted in the completing cycle.
REQ-024 chan_en or mode changes during SEND have no effect on the word in flight.
REQ-025 out_valid = 0 in IDLE; out_data retains last captured word in IDLE.
REQ-026 out_valid is never multi-hot.

Reset
REQ-027 rst = 1 at a rising edge: FSM <= IDLE, out_valid <= 0, out_data <= 16'h0000, drop <= 0, xfer_count <= 0, rr_ptr <= 15 (first round-robin grant = lowest enabled channel).
REQ-028 Reset during SEND discards the held word without completion; no drop pulse, no count increment.
REQ-029 rst overrides in_valid and out_ready in the same cycle.

Verification
REQ-030 Addressed sweep: mode=0, chan_en=16'hFFFF, out_ready=16'hFFFF, in_data=16'hFFFF, in_dest 0..15 -> out_valid = 1<<dest one cycle after each accept, out_data=16'hFFFF, xfer_count = 16 at end.
REQ-031 Backpressure: mode=0, in_dest=5, out_ready[5]=0 for 4 cycles then 1 -> out_valid=16'h0020 stable 5 cycles, in_ready=0 throughout, then IDLE, xfer_count+1.
REQ-032 Round-robin skip/wrap: mode=1, chan_en=16'h8011, 5 words -> grants to channels 0,4,15,0,4.
REQ-033 Drop: mode=0, chan_en=16'hFFFE, in_dest=0 -> drop pulse 1 cycle, out_valid stays 0, xfer_count unchanged; mode=1, chan_en=0 -> same.
REQ-034 Reset mid-SEND: rst=1 while out_valid=16'h0100 -> next cycle out_valid=0, out_data=0, xfer_count=0, in_ready=1; next round-robin grant = channel 0.
REQ-035 Counter wrap: 256 completed transfers -> xfer_count returns to 8'h00.
